// File: rtl/spi_cmd_sequencer.sv
// SPI command decoder/sequencer: frames received bytes into commands, updates core
// registers, streams ROM downloads and serves config-string readback. Macro ROM_CHECKSUM_EN adds command 0x08.
module spi_cmd_sequencer #(
  parameter int STR_AW = 6,
  parameter int LEN_W  = 24
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              frame_active,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  input  logic              tx_next,
  output logic [7:0]        tx_byte,
  output logic [STR_AW-1:0] str_addr,
  input  logic [7:0]        str_data,
  output logic [31:0]       core_config,
  output logic [15:0]       ctrl_word,
  output logic              rom_loading,
  output logic [7:0]        rom_do,
  output logic              rom_do_valid,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ARG, STREAM, DRAIN} state_t;

  localparam logic [7:0] CMD_STR  = 8'h01;
  localparam logic [7:0] CMD_CFG  = 8'h02;
  localparam logic [7:0] CMD_CTRL = 8'h04;
  localparam logic [7:0] CMD_ROM  = 8'h07;
`ifdef ROM_CHECKSUM_EN
  localparam logic [7:0] CMD_SUM  = 8'h08;
`endif

  state_t            state, state_nxt;
  logic [7:0]        cmd;
  logic [2:0]        arg_cnt;
  logic [23:0]       args;
  logic [LEN_W-1:0]  rem;
  logic              cmd_ok;
  logic              str_mode;

  logic              cmd_byte, arg_byte, arg_last, stream_byte;
  logic [2:0]        cmd_args;
  logic [23:0]       len24;
  logic [LEN_W-1:0]  len;

`ifdef ROM_CHECKSUM_EN
  logic [15:0]       sum;
  logic              sum_mode;
  logic [1:0]        sum_idx;
`endif

  // Argument count per command; zero means unknown command.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    cmd_args = 3'd0;
    case (rx_byte)
      CMD_STR:  cmd_args = 3'd1;
      CMD_CFG:  cmd_args = 3'd4;
      CMD_CTRL: cmd_args = 3'd2;
      CMD_ROM:  cmd_args = 3'd3;
`ifdef ROM_CHECKSUM_EN
      CMD_SUM:  cmd_args = 3'd1;
`endif
      default:  cmd_args = 3'd0;
    endcase
  end

  assign len24 = {args[15:0], rx_byte};
  assign len   = LEN_W'(len24);

  always_comb begin
    state_nxt   = state;
    cmd_byte    = 1'b0;
    arg_byte    = 1'b0;
    stream_byte = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid && cmd_ok) begin
          cmd_byte  = 1'b1;
          state_nxt = (cmd_args == 3'd0) ? DRAIN : ARG;
        end
      end
      ARG: begin
        if (rx_valid) begin
          arg_byte = 1'b1;
          if (arg_cnt == 3'd1)
            state_nxt = (cmd == CMD_ROM && len != '0) ? STREAM : DRAIN;
        end
      end
      STREAM: begin
        if (rx_valid) begin
          stream_byte = 1'b1;
          if (rem == LEN_W'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN:   state_nxt = DRAIN;
      default: state_nxt = IDLE;
    endcase
    // The byte of this cycle is still decoded above; the frame end wins for the state.
    if (!frame_active) state_nxt = IDLE;
  end

  assign arg_last = arg_byte && (arg_cnt == 3'd1);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cmd          <= '0;
      arg_cnt      <= '0;
      args         <= '0;
      rem          <= '0;
      cmd_ok       <= 1'b0;
      str_mode     <= 1'b0;
      str_addr     <= '0;
      core_config  <= '0;
      ctrl_word    <= '0;
      rom_loading  <= 1'b0;
      rom_do       <= '0;
      rom_do_valid <= 1'b0;
`ifdef ROM_CHECKSUM_EN
      sum          <= '0;
      sum_mode     <= 1'b0;
      sum_idx      <= '0;
`endif
    end else begin
      rom_do_valid <= 1'b0;

      // A reset inside a frame leaves cmd_ok low, so the rest of that frame is ignored.
      if (!frame_active) cmd_ok <= 1'b1;
      else if (cmd_byte) cmd_ok <= 1'b0;

      if (cmd_byte) begin
        cmd      <= rx_byte;
        arg_cnt  <= cmd_args;
        str_mode <= 1'b0;
`ifdef ROM_CHECKSUM_EN
        sum_mode <= 1'b0;
`endif
      end

      if (arg_byte) begin
        args    <= {args[15:0], rx_byte};
        arg_cnt <= arg_cnt - 3'd1;
      end

      // Arguments commit only on the final byte, so aborted frames change nothing.
      if (arg_last) begin
        case (cmd)
          CMD_STR: begin
            str_mode <= 1'b1;
            str_addr <= '0;
          end
          CMD_CFG:  core_config <= {args, rx_byte};
          CMD_CTRL: ctrl_word   <= {args[7:0], rx_byte};
          CMD_ROM: begin
            if (len != '0 && frame_active) begin
              rom_loading <= 1'b1;
              rem         <= len;
`ifdef ROM_CHECKSUM_EN
              sum         <= '0;
`endif
            end
          end
`ifdef ROM_CHECKSUM_EN
          CMD_SUM: begin
            sum_mode <= 1'b1;
            sum_idx  <= '0;
          end
`endif
          default: ;
        endcase
      end

      if (stream_byte) begin
        rom_do       <= rx_byte;
        rom_do_valid <= 1'b1;
        rem          <= rem - LEN_W'(1);
`ifdef ROM_CHECKSUM_EN
        sum          <= sum + {8'h00, rx_byte};
`endif
      end

      // Last byte: drop rom_loading as its strobe cycle ends. Frame end with bytes owed: abort.
      if (rom_do_valid && rem == '0) begin
        rom_loading <= 1'b0;
      end else if (!frame_active && rom_loading && !(stream_byte && rem == LEN_W'(1))) begin
        rom_loading <= 1'b0;
        rem         <= '0;
      end

      // Address sticks on the terminating 0x00 so it repeats.
      if (str_mode && tx_next && str_data != 8'h00)
        str_addr <= str_addr + STR_AW'(1);

`ifdef ROM_CHECKSUM_EN
      if (sum_mode && tx_next && sum_idx != 2'd2)
        sum_idx <= sum_idx + 2'd1;
`endif
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    if (str_mode) begin
      tx_byte = str_data;
    end
`ifdef ROM_CHECKSUM_EN
    else if (sum_mode) begin
      case (sum_idx)
        2'd0:    tx_byte = sum[15:8];
        2'd1:    tx_byte = sum[7:0];
        default: tx_byte = 8'h00;
      endcase
    end
`endif
  end

endmodule

// File: doc/spi_cmd_sequencer.md
Name: spi_cmd_sequencer

Overview:
- Command decoder and sequencer between the SPI-slave byte PHY and the monitor core's resources: core config register, 16-bit control word, ROM download stream and config-string readback.
- Consumes received bytes framed by chip-select, runs the per-command argument state machine, and drives the TX byte the PHY shifts out next.
- Sits inside sys, between the SPI PHY and the core/overlay logic.

Parameters:
- STR_AW, 6, config-string ROM address width (max 64 bytes incl. terminating 0x00)
- LEN_W, 24, ROM download length counter width

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- frame_active  in  1  high while SPI CS is asserted; falling edge ends frame
- rx_byte  in  8  received byte from PHY
- rx_valid  in  1  one-cycle strobe, rx_byte valid; at most one per 4 clk
- tx_next  in  1  one-cycle strobe: PHY latched tx_byte, advance
- tx_byte  out  8  byte PHY shifts out next
- str_addr  out  STR_AW  config-string ROM address (ROM read latency 1 clk)
- str_data  in  8  config-string ROM data
- core_config  out  32  core configuration register
- ctrl_word  out  16  control word (overlay/misc)
- rom_loading  out  1  ROM download in progress
- rom_do  out  8  ROM data byte
- rom_do_valid  out  1  one-cycle strobe per ROM byte
- busy  out  1  state != IDLE

Behaviour:
- Reset (resetn=0 at clk edge): state IDLE. core_config=0, ctrl_word=0, rom_loading=0, rom_do=0, rom_do_valid=0, str_addr=0, tx_byte=0, busy=0.
- Frame start: first rx_valid after frame_active rises is the command byte.
- States:
  - IDLE: wait for the command byte.
  - ARG: collect big-endian argument bytes; arg_cnt counts down.
  - STREAM: ROM data bytes.
  - DRAIN: ignore bytes until frame end.
- Any frame_active low forces IDLE on the next clk. Uncommitted arguments are discarded, so registers are never partially updated.
- Commands:
  - 0x01, 1 dummy arg: on the arg byte, str_addr:=0 and string mode is armed.
    - Readback frames follow, one byte per tx_next. tx_byte=str_data.
    - str_addr increments on tx_next unless the current str_data==0x00. It then sticks, so 0x00 repeats.
    - String mode ends on any new command byte.
  - 0x02, 4 args: core_config updates on the cycle after the 4th rx_valid; all 32 bits change at once.
  - 0x04, 2 args: ctrl_word updates after the 2nd byte.
  - 0x07, 3 length bytes then data:
    - rom_loading rises the cycle after the 3rd length byte if length != 0. Length 0 goes to DRAIN, rom_loading stays 0.
    - Each data byte: rom_do=rx_byte and rom_do_valid=1 for exactly one clk, 1 clk after rx_valid.
    - rem counter (LEN_W) decrements per byte. On the last byte rom_loading falls together with the rom_do_valid cycle ending, and the state goes to DRAIN.
    - Extra bytes in the frame are dropped.
  - Frame end while rem != 0 (abort): rom_loading falls next clk, no further rom_do_valid.
  - Any other command: DRAIN.
- tx_byte is 0x00 when not in string mode, except for 0x08 (see Optional Feature).
- rx_valid and frame_active falling in the same clk: the byte is processed first, then IDLE.

Optional Feature:
- Macro ROM_CHECKSUM_EN.
- Defined:
  - A 16-bit modular sum of all rom_do bytes is cleared when rom_loading rises.
  - Command 0x08 (1 dummy arg) arms sum mode: tx_byte = sum[15:8], then sum[7:0] after the first tx_next, then 0x00.
- Undefined: 0x08 is an unknown command (DRAIN), and no sum logic is present.

Test Plan:
- Config string: ROM holds "NES\0". Send frame {01,00}, then 6 single-byte read frames -> tx_byte sequence 4E,45,53,00,00,00; str_addr stops at 3.
- Config write: frame {02,A5,A5,A5,A5} -> core_config=A5A5A5A5 one clk after 4th byte. Frame {02,11,22} then CS high -> core_config unchanged.
- ROM stream: frame {07,00,00,03,AA,BB,CC,DD} -> rom_loading high for bytes AA,BB,CC. Exactly 3 rom_do_valid pulses; DD ignored; rom_loading=0 after CC.
- Abort: frame {07,00,00,10} plus 5 bytes, then CS high -> 5 strobes; rom_loading low 1 clk after frame end. Next frame {04,12,34} -> ctrl_word=1234.
- Reset mid-stream: resetn=0 for 1 clk during STREAM -> all outputs at reset values next clk; following bytes in that frame produce no strobes.
- ROM_CHECKSUM_EN: stream {07,00,00,02,01,FF}, then {08,00} and 2 reads -> tx_byte 01,00.
